// File: rtl/exec_multicycle_sequencer_pkg.sv
// Shared types for the execute-stage multi-cycle sequencer.
// MC_WATCHDOG mirrors the optional MC_WATCHDOG_EN build macro.
package exec_multicycle_sequencer_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DONE  = 2'd2,
    MC_DRAIN = 2'd3
  } mc_state_t;

`ifdef MC_WATCHDOG_EN
  localparam bit MC_WATCHDOG = 1'b1;
`else
  localparam bit MC_WATCHDOG = 1'b0;
`endif

  typedef struct packed {
    logic       issue_valid;
    logic [4:0] issue_waddr;
    logic       issue_fpdest;
    logic       clear;
    logic       hold;
  } mc_in_type;

  typedef struct packed {
    logic stall;
    logic wb_valid;
    logic busy;
  } mc_out_type;

  // Channel-index width; a single channel still needs a 1-bit index port.
  function automatic int unit_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_multicycle_sequencer_if.sv
// Issue / unit / write-back bundle between execute and the multi-cycle sequencer.
interface exec_multicycle_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int NUNITS = 3,
  parameter int FLAGW  = 5
) ();
  import exec_multicycle_sequencer_pkg::*;

  localparam int UW = unit_w(NUNITS);

  logic                    issue_valid;
  logic [UW-1:0]           issue_unit;
  logic [4:0]              issue_waddr;
  logic                    issue_fpdest;
  logic                    clear;
  logic                    hold;
  logic [NUNITS-1:0]       unit_enable;
  logic [NUNITS-1:0]       unit_ready;
  logic [NUNITS*XLEN-1:0]  unit_result;
  logic [NUNITS*FLAGW-1:0] unit_flags;
  logic                    stall;
  logic                    wb_valid;
  logic [4:0]              wb_waddr;
  logic                    wb_fp;
  logic [XLEN-1:0]         wb_data;
  logic [FLAGW-1:0]        wb_flags;
  logic                    busy;
  logic                    timeout_err;

  modport master (
    output issue_valid, issue_unit, issue_waddr, issue_fpdest, clear, hold,
    output unit_ready, unit_result, unit_flags,
    input  unit_enable, stall, wb_valid, wb_waddr, wb_fp, wb_data, wb_flags,
    input  busy, timeout_err
  );

  modport slave (
    input  issue_valid, issue_unit, issue_waddr, issue_fpdest, clear, hold,
    input  unit_ready, unit_result, unit_flags,
    output unit_enable, stall, wb_valid, wb_waddr, wb_fp, wb_data, wb_flags,
    output busy, timeout_err
  );

endinterface

// File: rtl/exec_multicycle_sequencer_mc_channel_mux.sv
// Channel fan-out/fan-in: one-hot start decode for the issuing channel and
// ready/result/flag select for the channel that owns the outstanding op.
module mc_channel_mux
  import exec_multicycle_sequencer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUNITS = 3,
  parameter int FLAGW  = 5,
  parameter int UW     = unit_w(NUNITS)
) (
  input  logic                    en_i,
  input  logic [UW-1:0]           en_sel_i,
  input  logic [UW-1:0]           sel_i,
  input  logic [NUNITS-1:0]       unit_ready_i,
  input  logic [NUNITS*XLEN-1:0]  unit_result_i,
  input  logic [NUNITS*FLAGW-1:0] unit_flags_i,
  output logic [NUNITS-1:0]       unit_enable_o,
  output logic                    ready_o,
  output logic [XLEN-1:0]         result_o,
  output logic [FLAGW-1:0]        flags_o
);

  always_comb begin
    unit_enable_o = '0;
    ready_o       = 1'b0;
    result_o      = '0;
    flags_o       = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (en_i && (en_sel_i == UW'(i))) unit_enable_o[i] = 1'b1;
      if (sel_i == UW'(i)) begin
        ready_o  = unit_ready_i[i];
        result_o = unit_result_i[i*XLEN +: XLEN];
        flags_o  = unit_flags_i[i*FLAGW +: FLAGW];
      end
    end
  end

endmodule

// File: rtl/exec_multicycle_sequencer.sv
// Single-outstanding issue/completion sequencer for the execute-stage multi-cycle units.
// Optional watchdog enabled by defining MC_WATCHDOG_EN.
module exec_multicycle_sequencer
  import exec_multicycle_sequencer_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUNITS  = 3,
  parameter int FLAGW   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  exec_multicycle_sequencer_if.slave  bus
);

  localparam int            UW = unit_w(NUNITS);
  localparam logic [UW:0]   NU = NUNITS[UW:0];

  if ((NUNITS < 1) || (NUNITS > 8) || (TIMEOUT < 2)) begin : g_bad_cfg
    $error("exec_multicycle_sequencer: NUNITS must be 1..8 and TIMEOUT >= 2");
  end

  mc_state_t        state_q, state_d;
  logic [UW-1:0]    unit_q, unit_d;
  logic [4:0]       waddr_q, waddr_d;
  logic             fp_q, fp_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [FLAGW-1:0] flags_q, flags_d;
  logic [4:0]       wb_waddr_q, wb_waddr_d;
  logic             wb_fp_q, wb_fp_d;

  mc_in_type        in_s;
  mc_out_type       out_s;
  logic             accept;
  logic             wd_fire;
  logic             ready_sel;
  logic [XLEN-1:0]  result_sel;
  logic [FLAGW-1:0] flags_sel;

  assign in_s.issue_valid  = bus.issue_valid;
  assign in_s.issue_waddr  = bus.issue_waddr;
  assign in_s.issue_fpdest = bus.issue_fpdest;
  assign in_s.clear        = bus.clear;
  assign in_s.hold         = bus.hold;

  assign accept = (state_q == MC_IDLE) && in_s.issue_valid && !in_s.clear && !in_s.hold
                  && ({1'b0, bus.issue_unit} < NU);

  mc_channel_mux #(
    .XLEN   (XLEN),
    .NUNITS (NUNITS),
    .FLAGW  (FLAGW),
    .UW     (UW)
  ) u_mux (
    .en_i          (accept),
    .en_sel_i      (bus.issue_unit),
    .sel_i         (unit_q),
    .unit_ready_i  (bus.unit_ready),
    .unit_result_i (bus.unit_result),
    .unit_flags_i  (bus.unit_flags),
    .unit_enable_o (bus.unit_enable),
    .ready_o       (ready_sel),
    .result_o      (result_sel),
    .flags_o       (flags_sel)
  );

`ifdef MC_WATCHDOG_EN
  // Counter reads k-1 in the k-th cycle after accept, so firing at TIMEOUT-2
  // lands the FSM in IDLE exactly TIMEOUT cycles after issue.
  localparam int TLIM = TIMEOUT - 2;
  logic [7:0] cnt_q, cnt_d;
  logic       terr_q;
  logic       waiting;

  assign waiting = (state_q == MC_BUSY) || (state_q == MC_DRAIN);
  assign wd_fire = waiting && (int'(cnt_q) >= TLIM);

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                          cnt_d = '0;
    else if (waiting && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wd_fire) terr_q <= 1'b1;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    waddr_d    = waddr_q;
    fp_d       = fp_q;
    data_d     = data_q;
    flags_d    = flags_q;
    wb_waddr_d = wb_waddr_q;
    wb_fp_d    = wb_fp_q;
    out_s      = '0;
    out_s.busy = (state_q != MC_IDLE);
    case (state_q)
      MC_IDLE: begin
        if (accept) begin
          out_s.stall = 1'b1;
          state_d     = MC_BUSY;
          unit_d      = bus.issue_unit;
          waddr_d     = in_s.issue_waddr;
          fp_d        = in_s.issue_fpdest;
        end
      end
      MC_BUSY: begin
        out_s.stall = 1'b1;
        if (wd_fire) begin
          // Let the pipeline move past the abandoned instruction.
          out_s.stall = 1'b0;
          state_d     = MC_IDLE;
        end else if (ready_sel) begin
          if (in_s.clear) begin
            state_d = MC_IDLE;
          end else begin
            state_d    = MC_DONE;
            data_d     = result_sel;
            flags_d    = flags_sel;
            wb_waddr_d = waddr_q;
            wb_fp_d    = fp_q;
          end
        end else if (in_s.clear) begin
          state_d = MC_DRAIN;
        end
      end
      MC_DONE: begin
        out_s.wb_valid = !in_s.hold && !in_s.clear;
        out_s.stall    = in_s.hold;
        if (!in_s.hold || in_s.clear) state_d = MC_IDLE;
      end
      MC_DRAIN: begin
        out_s.stall = in_s.issue_valid;
        if (wd_fire || ready_sel) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= MC_IDLE;
      unit_q     <= '0;
      waddr_q    <= '0;
      fp_q       <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
      wb_waddr_q <= '0;
      wb_fp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      waddr_q    <= waddr_d;
      fp_q       <= fp_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      wb_waddr_q <= wb_waddr_d;
      wb_fp_q    <= wb_fp_d;
    end
  end

  assign bus.stall    = out_s.stall;
  assign bus.wb_valid = out_s.wb_valid;
  assign bus.busy     = out_s.busy;
  assign bus.wb_waddr = wb_waddr_q;
  assign bus.wb_fp    = wb_fp_q;
  assign bus.wb_data  = data_q;
  assign bus.wb_flags = flags_q;

endmodule

// File: tb/tb_exec_multicycle_sequencer.sv
// Bench for exec_multicycle_sequencer: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_exec_multicycle_sequencer;

  localparam int XLEN   = 32;
  localparam int NUNITS = 3;
  localparam int FLAGW  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  exec_multicycle_sequencer_if #(.XLEN(XLEN), .NUNITS(NUNITS), .FLAGW(FLAGW)) bus ();

  exec_multicycle_sequencer #(
    .XLEN(XLEN), .NUNITS(NUNITS), .FLAGW(FLAGW), .TIMEOUT(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          unit;
    logic [4:0]  waddr;
    bit          fp;
    int          lat;
    logic [31:0] res;
    logic [4:0]  flg;
    logic [2:0]  exp_en;
    bit          exp_wb;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_data;
    bit          exp_fp;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet_units();
    bus.unit_ready  = '0;
    bus.unit_result = '0;
    bus.unit_flags  = '0;
  endtask

  task automatic set_ready(input int u, input logic [31:0] r, input logic [4:0] f);
    quiet_units();
    bus.unit_ready[u]                 = 1'b1;
    bus.unit_result[u*XLEN +: XLEN]   = r;
    bus.unit_flags[u*FLAGW +: FLAGW]  = f;
  endtask

  task automatic drive_issue(input int u, input logic [4:0] wa, input bit fp);
    bus.issue_valid  = 1'b1;
    bus.issue_unit   = 2'(u);
    bus.issue_waddr  = wa;
    bus.issue_fpdest = fp;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    quiet_units();
    drive_issue(v.unit, v.waddr, v.fp);
    #1;
    chk("vec_enable", bus.unit_enable, v.exp_en);
    chk("vec_stall_issue", bus.stall, v.exp_wb);
    if (v.exp_wb) begin
      for (int c = 1; c <= v.lat; c++) begin
        @(negedge clock);
        if (c == v.lat) set_ready(v.unit, v.res, v.flg);
        #1;
        chk("vec_stall_wait", bus.stall, 1);
        chk("vec_wbv_wait", bus.wb_valid, 0);
      end
      @(negedge clock);
      quiet_units();
      #1;
      chk("vec_wb_valid", bus.wb_valid, 1);
      chk("vec_stall_wb", bus.stall, 0);
      chk("vec_wb_waddr", bus.wb_waddr, v.exp_waddr);
      chk("vec_wb_data", bus.wb_data, v.exp_data);
      chk("vec_wb_fp", bus.wb_fp, v.exp_fp);
      chk("vec_wb_flags", bus.wb_flags, v.exp_flags);
    end
    @(negedge clock);
    bus.issue_valid = 1'b0;
    #1;
    chk("vec_busy_after", bus.busy, 0);
    chk("vec_wbv_after", bus.wb_valid, 0);
  endtask

  // Reference model: at most one op in flight, described by what has happened to it.
  bit               m_op, m_have, m_flush, retire;
  int               m_unit, iu;
  logic [4:0]       m_waddr;
  bit               m_fp;
  logic [XLEN-1:0]  m_data;
  logic [FLAGW-1:0] m_flags;
  logic [NUNITS-1:0] e_en;
  bit               e_stall, e_wbv, e_busy;
  int               rem[NUNITS];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{0, 5'd5,  1'b0, 4, 32'hDEADBEEF, 5'h00, 3'b001, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'h00};
    vecs[1] = '{1, 5'd31, 1'b1, 1, 32'h12345678, 5'h1F, 3'b010, 1'b1, 5'd31, 32'h12345678, 1'b1, 5'h1F};
    vecs[2] = '{2, 5'd0,  1'b0, 2, 32'hFFFFFFFF, 5'h10, 3'b100, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'h10};
    vecs[3] = '{3, 5'd7,  1'b1, 1, 32'h0,        5'h00, 3'b000, 1'b0, 5'd0,  32'h0,        1'b0, 5'h00};

    bus.issue_valid = 1'b0; bus.issue_unit = '0; bus.issue_waddr = '0; bus.issue_fpdest = 1'b0;
    bus.clear = 1'b0; bus.hold = 1'b0;
    quiet_units();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_enable", bus.unit_enable, 0);
    chk("rst_timeout", bus.timeout_err, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Result lands under a 3-cycle hold: held, then written back on release.
    @(negedge clock); drive_issue(1, 5'd9, 1'b0); #1;
    chk("hold_en", bus.unit_enable, 3'b010);
    @(negedge clock); #1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      bus.hold = 1'b1;
      if (c == 2) set_ready(1, 32'hA5A50001, 5'h03); else quiet_units();
      #1;
      chk("hold_stall", bus.stall, 1);
      chk("hold_wbv", bus.wb_valid, 0);
    end
    @(negedge clock); bus.hold = 1'b0; #1;
    chk("hold_release_wbv", bus.wb_valid, 1);
    chk("hold_release_stall", bus.stall, 0);
    chk("hold_data", bus.wb_data, 32'hA5A50001);
    chk("hold_waddr", bus.wb_waddr, 5'd9);
    @(negedge clock); bus.issue_valid = 1'b0; #1;

    // Flush during a 6-cycle op: drain, then the waiting issue starts right after.
    @(negedge clock); drive_issue(0, 5'd12, 1'b0); #1;
    chk("drain_en0", bus.unit_enable, 3'b001);
    @(negedge clock); #1;
    @(negedge clock); bus.clear = 1'b1; bus.issue_valid = 1'b0; #1;
    chk("drain_clear_stall", bus.stall, 1);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clock);
      bus.clear = 1'b0;
      drive_issue(1, 5'd20, 1'b1);
      if (c == 6) set_ready(0, 32'hBAD0BAD0, 5'h1F);
      #1;
      chk("drain_stall", bus.stall, 1);
      chk("drain_no_en", bus.unit_enable, 0);
      chk("drain_no_wbv", bus.wb_valid, 0);
    end
    @(negedge clock); quiet_units(); #1;
    chk("drain_new_en", bus.unit_enable, 3'b010);
    chk("drain_new_stall", bus.stall, 1);
    @(negedge clock); #1;
    @(negedge clock); set_ready(1, 32'h0000_7777, 5'h02); #1;
    @(negedge clock); quiet_units(); #1;
    chk("drain_new_wbv", bus.wb_valid, 1);
    chk("drain_new_data", bus.wb_data, 32'h0000_7777);
    chk("drain_new_waddr", bus.wb_waddr, 5'd20);
    @(negedge clock); bus.issue_valid = 1'b0; #1;

    // FP destination on unit 2; a stray ready on unit 1 must not complete it.
    @(negedge clock); drive_issue(2, 5'd3, 1'b1); #1;
    chk("fp_en", bus.unit_enable, 3'b100);
    @(negedge clock); set_ready(1, 32'h1111_1111, 5'h04); #1;
    chk("fp_stray_stall", bus.stall, 1);
    @(negedge clock); set_ready(2, 32'h3F80_0000, 5'b00001); #1;
    chk("fp_ready_wbv", bus.wb_valid, 0);
    @(negedge clock); quiet_units(); #1;
    chk("fp_wbv", bus.wb_valid, 1);
    chk("fp_wb_fp", bus.wb_fp, 1);
    chk("fp_wb_flags", bus.wb_flags, 5'b00001);
    chk("fp_wb_data", bus.wb_data, 32'h3F80_0000);
    @(negedge clock); bus.issue_valid = 1'b0; #1;

    // Reset while an op is in flight clears everything.
    @(negedge clock); drive_issue(0, 5'd17, 1'b1); #1;
    @(negedge clock); #1;
    chk("rstbusy_busy_before", bus.busy, 1);
    @(negedge clock); reset = 1'b1; bus.issue_valid = 1'b0; #1;
    @(negedge clock); reset = 1'b0; #1;
    chk("rstbusy_busy", bus.busy, 0);
    chk("rstbusy_stall", bus.stall, 0);
    chk("rstbusy_wbv", bus.wb_valid, 0);
    chk("rstbusy_waddr", bus.wb_waddr, 0);
    chk("rstbusy_fp", bus.wb_fp, 0);
    chk("rstbusy_flags", bus.wb_flags, 0);
    chk("rstbusy_data", bus.wb_data, 0);

`ifdef MC_WATCHDOG_EN
    @(negedge clock); drive_issue(0, 5'd1, 1'b0); #1;
    chk("wd_en", bus.unit_enable, 3'b001);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock); #1;
      chk("wd_stall", bus.stall, (c == 7) ? 1'b0 : 1'b1);
      chk("wd_wbv_wait", bus.wb_valid, 0);
    end
    @(negedge clock); bus.issue_valid = 1'b0; #1;
    chk("wd_idle", bus.busy, 0);
    chk("wd_err", bus.timeout_err, 1);
    chk("wd_no_wbv", bus.wb_valid, 0);
`else
    chk("wd_tied_off", bus.timeout_err, 0);
`endif

    // Random traffic against the reference model.
    m_op = 0; m_have = 0; m_flush = 0; retire = 0; m_unit = 0;
    m_waddr = '0; m_fp = 0; m_data = '0; m_flags = '0;
    for (int i = 0; i < NUNITS; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (retire) bus.issue_valid = 1'b0;
      if (!bus.issue_valid && ($urandom_range(0, 2) == 0))
        drive_issue(int'($urandom_range(0, 3)), 5'($urandom), 1'($urandom));
      bus.clear = ($urandom_range(0, 11) == 0);
      bus.hold  = ($urandom_range(0, 3) == 0);
      bus.unit_ready = '0;
      for (int i = 0; i < NUNITS; i++) begin
        bus.unit_result[i*XLEN +: XLEN]  = $urandom;
        bus.unit_flags[i*FLAGW +: FLAGW] = 5'($urandom);
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) bus.unit_ready[i] = 1'b1;
        end else if ((!m_op || m_unit != i) && ($urandom_range(0, 7) == 0)) begin
          bus.unit_ready[i] = 1'b1;
        end
      end
      #1;
      iu = int'(bus.issue_unit);
      e_en = '0; e_stall = 0; e_wbv = 0; e_busy = m_op;
      if (!m_op) begin
        if (bus.issue_valid && !bus.clear && !bus.hold && iu < NUNITS) begin
          e_en[iu] = 1'b1; e_stall = 1;
          m_op = 1; m_have = 0; m_flush = 0; m_unit = iu;
          m_waddr = bus.issue_waddr; m_fp = bus.issue_fpdest;
        end
      end else if (m_have) begin
        e_stall = bus.hold;
        e_wbv   = !bus.hold && !bus.clear;
        if (!bus.hold || bus.clear) m_op = 0;
      end else if (m_flush) begin
        e_stall = bus.issue_valid;
        if (bus.unit_ready[m_unit]) m_op = 0;
      end else begin
        e_stall = 1;
        if (bus.unit_ready[m_unit]) begin
          if (bus.clear) m_op = 0;
          else begin
            m_have  = 1;
            m_data  = bus.unit_result[m_unit*XLEN +: XLEN];
            m_flags = bus.unit_flags[m_unit*FLAGW +: FLAGW];
          end
        end else if (bus.clear) begin
          m_flush = 1;
        end
      end
      chk("rnd_enable", bus.unit_enable, e_en);
      chk("rnd_stall", bus.stall, e_stall);
      chk("rnd_wb_valid", bus.wb_valid, e_wbv);
      chk("rnd_busy", bus.busy, e_busy);
      if (e_wbv) begin
        chk("rnd_wb_waddr", bus.wb_waddr, m_waddr);
        chk("rnd_wb_fp", bus.wb_fp, m_fp);
        chk("rnd_wb_data", bus.wb_data, m_data);
        chk("rnd_wb_flags", bus.wb_flags, m_flags);
      end
      for (int i = 0; i < NUNITS; i++)
        if (bus.unit_enable[i]) rem[i] = int'($urandom_range(1, 6));
      retire = bus.issue_valid && (bus.clear || (!e_stall && !bus.hold));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
